// File: rtl/borg_cmd_bridge.sv
// borg_cmd_bridge
// Peripheral-bus slave bridging the CPU to the Borg compute core. CPU writes
// to CMD are queued in a command FIFO and streamed to the core. Core results
// are queued in a result FIFO that the CPU drains by reading RESULT, with the
// bus stalled while that FIFO is empty.
//
// Handshake semantics (both streams): a beat transfers on a clock edge where
// valid && ready are both 1. The producer keeps bits stable while valid is
// high and ready is low. Valid never depends on ready in this block.
module borg_cmd_bridge #(
   parameter int CMD_DEPTH = 4,
   parameter int RES_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  io_address,
   input  logic [31:0] io_data_in,
   input  logic [1:0]  io_data_write_n,
   input  logic [1:0]  io_data_read_n,
   output logic [31:0] io_data_out,
   output logic        io_data_ready,
   output logic        io_user_interrupt,
   output logic        io_cmd_valid,
   input  logic        io_cmd_ready,
   output logic [31:0] io_cmd_bits,
   input  logic        io_res_valid,
   output logic        io_res_ready,
   input  logic [31:0] io_res_bits
);

   localparam int CAW = $clog2(CMD_DEPTH);
   localparam int RAW = $clog2(RES_DEPTH);

   localparam logic [5:0] ADDR_CMD    = 6'h00;
   localparam logic [5:0] ADDR_RESULT = 6'h04;
   localparam logic [5:0] ADDR_STATUS = 6'h08;
   localparam logic [5:0] ADDR_CTRL   = 6'h0C;

   localparam logic [CAW:0] CMD_FULL_CNT = (CAW+1)'(CMD_DEPTH);
   localparam logic [RAW:0] RES_FULL_CNT = (RAW+1)'(RES_DEPTH);

   // ---------------------------------------------------------------------
   // Storage and control state
   // ---------------------------------------------------------------------
   logic [31:0]  cmd_mem [CMD_DEPTH];
   logic [31:0]  res_mem [RES_DEPTH];
   logic [CAW:0] cmd_wr_ptr, cmd_rd_ptr;
   logic [RAW:0] res_wr_ptr, res_rd_ptr;
   logic         overflow;
   logic         ie;
   logic         served;
   logic         irq_q;

   // ---------------------------------------------------------------------
   // Derived status
   // ---------------------------------------------------------------------
   logic [CAW:0] cmd_count;
   logic [RAW:0] res_count;
   logic         cmd_empty, cmd_full;
   logic         res_empty, res_full;

   assign cmd_count = cmd_wr_ptr - cmd_rd_ptr;
   assign res_count = res_wr_ptr - res_rd_ptr;
   assign cmd_empty = (cmd_count == '0);
   assign cmd_full  = (cmd_count == CMD_FULL_CNT);
   assign res_empty = (res_count == '0);
   assign res_full  = (res_count == RES_FULL_CNT);

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   logic        wr_active, rd_active;
   logic [31:0] wdata;
   logic        rd_result;
   logic        flush;
   logic        cmd_wr_req, cmd_push, cmd_pop, cmd_drop;
   logic        res_push, res_pop;
   logic        status_clr;
   logic        ctrl_wr;

   assign wr_active = (io_data_write_n != 2'b11);
   assign rd_active = (io_data_read_n  != 2'b11);

   // Zero-extend the write data according to the access size.
   always_comb begin
      wdata = io_data_in;
      case (io_data_write_n)
         2'b00:   wdata = {24'h0, io_data_in[7:0]};
         2'b01:   wdata = {16'h0, io_data_in[15:0]};
         default: wdata = io_data_in;
      endcase
   end

   assign ctrl_wr    = wr_active && (io_address == ADDR_CTRL);
   assign flush      = ctrl_wr && wdata[0];
   assign status_clr = wr_active && (io_address == ADDR_STATUS) && wdata[2];

   // A CMD write into a full FIFO still lands if the core frees a slot in
   // the same cycle; otherwise it is dropped and flagged as overflow.
   assign cmd_wr_req = wr_active && (io_address == ADDR_CMD) && !flush;
   assign cmd_pop    = io_cmd_valid && io_cmd_ready && !flush;
   assign cmd_push   = cmd_wr_req && (!cmd_full || cmd_pop);
   assign cmd_drop   = cmd_wr_req && cmd_full && !cmd_pop;

   // Only the first cycle of a RESULT read transaction may pop.
   assign rd_result = rd_active && (io_address == ADDR_RESULT);
   assign res_push  = io_res_valid && io_res_ready && !flush;
   assign res_pop   = rd_result && !served && !res_empty && !flush;

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign io_cmd_valid      = !cmd_empty;
   assign io_cmd_bits       = cmd_empty ? 32'h0 : cmd_mem[cmd_rd_ptr[CAW-1:0]];
   assign io_res_ready      = !res_full;
   assign io_user_interrupt = irq_q;

   // A RESULT read stalls only on its first cycle while nothing is queued.
   assign io_data_ready = !(rd_result && !served && res_empty);

   // Read mux: combinational from the addressed register.
   always_comb begin
      io_data_out = 32'h0;
      case (io_address)
         ADDR_RESULT: io_data_out = res_empty ? 32'h0 : res_mem[res_rd_ptr[RAW-1:0]];
         ADDR_STATUS: begin
            io_data_out[0]             = res_empty;
            io_data_out[1]             = cmd_full;
            io_data_out[2]             = overflow;
            io_data_out[8 +: CAW+1]    = cmd_count;
            io_data_out[16 +: RAW+1]   = res_count;
         end
         ADDR_CTRL:   io_data_out[1] = ie;
         default:     io_data_out = 32'h0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Sequential logic
   // ---------------------------------------------------------------------

   // Command FIFO data storage (contents need no reset; pointers gate use).
   always_ff @(posedge clock) begin
      if (cmd_push) cmd_mem[cmd_wr_ptr[CAW-1:0]] <= wdata;
   end

   // Command FIFO pointers; flush and reset both empty the queue.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
      end else begin
         if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
         if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      end
   end

   // Result FIFO data storage.
   always_ff @(posedge clock) begin
      if (res_push) res_mem[res_wr_ptr[RAW-1:0]] <= io_res_bits;
   end

   // Result FIFO pointers; flush and reset both empty the queue.
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         res_wr_ptr <= '0;
         res_rd_ptr <= '0;
      end else begin
         if (res_push) res_wr_ptr <= res_wr_ptr + 1'b1;
         if (res_pop)  res_rd_ptr <= res_rd_ptr + 1'b1;
      end
   end

   // Sticky overflow: set by a dropped CMD write, cleared by STATUS or flush.
   always_ff @(posedge clock) begin
      if (reset || flush || status_clr) overflow <= 1'b0;
      else if (cmd_drop)                overflow <= 1'b1;
   end

   // Interrupt enable, written through CTRL bit1.
   always_ff @(posedge clock) begin
      if (reset)        ie <= 1'b0;
      else if (ctrl_wr) ie <= wdata[1];
   end

   // Served flag marks a read transaction that has already completed once.
   always_ff @(posedge clock) begin
      if (reset || !rd_active) served <= 1'b0;
      else if (io_data_ready)  served <= 1'b1;
   end

   // Registered interrupt: follows state with one cycle of latency.
   always_ff @(posedge clock) begin
      if (reset) irq_q <= 1'b0;
      else       irq_q <= ie && !res_empty;
   end

endmodule

// File: tb/tb_borg_cmd_bridge.sv
// Directed bench for borg_cmd_bridge: command streaming, overflow, stalled
// result reads, interrupt latency, flush and reset-while-stalled.
module tb_borg_cmd_bridge;

   logic        clock;
   logic        reset;
   logic [5:0]  io_address;
   logic [31:0] io_data_in;
   logic [1:0]  io_data_write_n;
   logic [1:0]  io_data_read_n;
   logic [31:0] io_data_out;
   logic        io_data_ready;
   logic        io_user_interrupt;
   logic        io_cmd_valid;
   logic        io_cmd_ready;
   logic [31:0] io_cmd_bits;
   logic        io_res_valid;
   logic        io_res_ready;
   logic [31:0] io_res_bits;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   borg_cmd_bridge #(.CMD_DEPTH(4), .RES_DEPTH(4)) dut (
      .clock             (clock),
      .reset             (reset),
      .io_address        (io_address),
      .io_data_in        (io_data_in),
      .io_data_write_n   (io_data_write_n),
      .io_data_read_n    (io_data_read_n),
      .io_data_out       (io_data_out),
      .io_data_ready     (io_data_ready),
      .io_user_interrupt (io_user_interrupt),
      .io_cmd_valid      (io_cmd_valid),
      .io_cmd_ready      (io_cmd_ready),
      .io_cmd_bits       (io_cmd_bits),
      .io_res_valid      (io_res_valid),
      .io_res_ready      (io_res_ready),
      .io_res_bits       (io_res_bits)
   );

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Advance to just after the next active edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
      io_address      = a;
      io_data_in      = d;
      io_data_write_n = sz;
      tick();
      io_data_write_n = 2'b11;
   endtask

   // Single-cycle read followed by one idle cycle so served clears.
   task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic r);
      io_address     = a;
      io_data_read_n = 2'b10;
      settle();
      d = io_data_out;
      r = io_data_ready;
      tick();
      io_data_read_n = 2'b11;
      tick();
   endtask

   task automatic push(input logic [31:0] v);
      io_res_valid = 1'b1;
      io_res_bits  = v;
      tick();
      io_res_valid = 1'b0;
   endtask

   logic [31:0] rdata;
   logic        rrdy;

   initial begin
      reset           = 1'b1;
      io_address      = 6'h0;
      io_data_in      = 32'h0;
      io_data_write_n = 2'b11;
      io_data_read_n  = 2'b11;
      io_cmd_ready    = 1'b0;
      io_res_valid    = 1'b0;
      io_res_bits     = 32'h0;
      tick();
      tick();
      reset = 1'b0;
      settle();

      // Reset state
      chk("rst_data_ready", 32'(io_data_ready), 32'd1);
      chk("rst_res_ready", 32'(io_res_ready), 32'd1);
      chk("rst_cmd_valid", 32'(io_cmd_valid), 32'd0);
      chk("rst_irq", 32'(io_user_interrupt), 32'd0);
      chk("rst_cmd_bits", io_cmd_bits, 32'h0);
      rd(6'h08, rdata, rrdy);
      chk("rst_status", rdata, 32'h0000_0001);

      // 1: queue three words, then stream them
      wr(6'h00, 32'h11, 2'b10);
      wr(6'h00, 32'h22, 2'b10);
      wr(6'h00, 32'h33, 2'b10);
      rd(6'h08, rdata, rrdy);
      chk("t1_status", rdata, 32'h0000_0301);
      chk("t1_head_stable", io_cmd_bits, 32'h11);
      io_cmd_ready = 1'b1;
      settle();
      chk("t1_bits0", io_cmd_bits, 32'h11);
      tick();
      chk("t1_bits1", io_cmd_bits, 32'h22);
      tick();
      chk("t1_bits2", io_cmd_bits, 32'h33);
      tick();
      chk("t1_empty", 32'(io_cmd_valid), 32'd0);
      io_cmd_ready = 1'b0;

      // Byte and half writes are zero-extended
      wr(6'h00, 32'hAABB_CCDD, 2'b00);
      wr(6'h00, 32'hAABB_CCDD, 2'b01);
      chk("byte_push", io_cmd_bits, 32'h0000_00DD);
      io_cmd_ready = 1'b1;
      tick();
      chk("half_push", io_cmd_bits, 32'h0000_CCDD);
      tick();
      chk("bh_empty", 32'(io_cmd_valid), 32'd0);
      io_cmd_ready = 1'b0;

      // 2: overflow on the fifth write, then clear it
      for (int i = 1; i <= 5; i++) wr(6'h00, 32'(i), 2'b10);
      rd(6'h08, rdata, rrdy);
      chk("t2_overflow", rdata, 32'h0000_0407);
      wr(6'h08, 32'h4, 2'b10);
      rd(6'h08, rdata, rrdy);
      chk("t2_ovf_clear", rdata, 32'h0000_0403);
      // Write into a full FIFO while the core pops: accepted, no overflow
      io_cmd_ready = 1'b1;
      wr(6'h00, 32'h6, 2'b10);
      io_cmd_ready = 1'b0;
      rd(6'h08, rdata, rrdy);
      chk("t2_full_pop_wr", rdata, 32'h0000_0403);
      io_cmd_ready = 1'b1;
      settle();
      chk("t2_drain0", io_cmd_bits, 32'h2);
      tick();
      chk("t2_drain1", io_cmd_bits, 32'h3);
      tick();
      chk("t2_drain2", io_cmd_bits, 32'h4);
      tick();
      chk("t2_drain3", io_cmd_bits, 32'h6);
      tick();
      chk("t2_drain_empty", 32'(io_cmd_valid), 32'd0);
      io_cmd_ready = 1'b0;

      // 3: stalled RESULT read released by a core push
      io_address     = 6'h04;
      io_data_read_n = 2'b10;
      settle();
      for (int i = 0; i < 5; i++) begin
         chk("t3_stall", 32'(io_data_ready), 32'd0);
         tick();
      end
      io_res_valid = 1'b1;
      io_res_bits  = 32'hDEAD_BEEF;
      settle();
      chk("t3_stall_push", 32'(io_data_ready), 32'd0);
      tick();
      io_res_valid = 1'b0;
      settle();
      chk("t3_ready", 32'(io_data_ready), 32'd1);
      chk("t3_data", io_data_out, 32'hDEAD_BEEF);
      tick();
      chk("t3_served", 32'(io_data_ready), 32'd1);
      io_data_read_n = 2'b11;
      tick();
      rd(6'h08, rdata, rrdy);
      chk("t3_status", rdata, 32'h0000_0001);

      // 4: held read pops exactly once
      push(32'hA);
      push(32'hB);
      io_address     = 6'h04;
      io_data_read_n = 2'b10;
      settle();
      chk("t4_rdy0", 32'(io_data_ready), 32'd1);
      chk("t4_data0", io_data_out, 32'hA);
      tick();
      chk("t4_rdy1", 32'(io_data_ready), 32'd1);
      tick();
      chk("t4_rdy2", 32'(io_data_ready), 32'd1);
      tick();
      io_data_read_n = 2'b11;
      tick();
      rd(6'h08, rdata, rrdy);
      chk("t4_status", rdata, 32'h0001_0000);
      rd(6'h04, rdata, rrdy);
      chk("t4_second", rdata, 32'hB);
      chk("t4_second_rdy", 32'(rrdy), 32'd1);

      // Simultaneous push and pop keeps the count
      push(32'h1);
      io_address     = 6'h04;
      io_data_read_n = 2'b10;
      io_res_valid   = 1'b1;
      io_res_bits    = 32'h2;
      settle();
      chk("pp_data", io_data_out, 32'h1);
      tick();
      io_res_valid   = 1'b0;
      io_data_read_n = 2'b11;
      tick();
      rd(6'h08, rdata, rrdy);
      chk("pp_status", rdata, 32'h0001_0000);
      rd(6'h04, rdata, rrdy);
      chk("pp_next", rdata, 32'h2);

      // Result FIFO full: res_ready drops and extra pushes are ignored
      for (int i = 0; i < 4; i++) push(32'h10 + 32'(i));
      chk("full_res_ready", 32'(io_res_ready), 32'd0);
      push(32'h14);
      rd(6'h08, rdata, rrdy);
      chk("full_status", rdata, 32'h0004_0000);
      for (int i = 0; i < 4; i++) begin
         rd(6'h04, rdata, rrdy);
         chk("full_drain", rdata, 32'h10 + 32'(i));
      end

      // 5: interrupt latency
      wr(6'h0C, 32'h2, 2'b10);
      rd(6'h0C, rdata, rrdy);
      chk("t5_ctrl", rdata, 32'h2);
      chk("t5_irq_idle", 32'(io_user_interrupt), 32'd0);
      push(32'h55);
      chk("t5_irq_lat", 32'(io_user_interrupt), 32'd0);
      tick();
      chk("t5_irq_set", 32'(io_user_interrupt), 32'd1);
      rd(6'h04, rdata, rrdy);
      chk("t5_data", rdata, 32'h55);
      chk("t5_irq_clear", 32'(io_user_interrupt), 32'd0);

      // 6: flush dominates a same-cycle core push
      for (int i = 0; i < 5; i++) wr(6'h00, 32'h40 + 32'(i), 2'b10);
      io_cmd_ready = 1'b1;
      tick();
      tick();
      io_cmd_ready = 1'b0;
      push(32'h71);
      push(32'h72);
      push(32'h73);
      rd(6'h08, rdata, rrdy);
      chk("t6_pre", rdata, 32'h0003_0204);
      io_res_valid = 1'b1;
      io_res_bits  = 32'h99;
      wr(6'h0C, 32'h1, 2'b10);
      io_res_valid = 1'b0;
      rd(6'h08, rdata, rrdy);
      chk("t6_post", rdata, 32'h0000_0001);
      chk("t6_cmd_valid", 32'(io_cmd_valid), 32'd0);
      rd(6'h0C, rdata, rrdy);
      chk("t6_ctrl", rdata, 32'h0);

      // Reset in the middle of a stalled read
      wr(6'h00, 32'h5, 2'b10);
      io_address     = 6'h04;
      io_data_read_n = 2'b10;
      settle();
      chk("rs_stall", 32'(io_data_ready), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      settle();
      chk("rs_cmd_flushed", 32'(io_cmd_valid), 32'd0);
      chk("rs_still_stall", 32'(io_data_ready), 32'd0);
      tick();
      chk("rs_stall2", 32'(io_data_ready), 32'd0);
      push(32'h77);
      settle();
      chk("rs_ready", 32'(io_data_ready), 32'd1);
      chk("rs_data", io_data_out, 32'h77);
      tick();
      io_data_read_n = 2'b11;
      tick();

      // Unmapped offset and CMD read return 0 with ready
      rd(6'h10, rdata, rrdy);
      chk("unmapped_data", rdata, 32'h0);
      chk("unmapped_rdy", 32'(rrdy), 32'd1);
      wr(6'h00, 32'h1234, 2'b10);
      rd(6'h00, rdata, rrdy);
      chk("cmd_read_zero", rdata, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/borg_cmd_bridge.md
Name: borg_cmd_bridge

Overview:
TinyQV peripheral-bus slave that sits between the peripheral wrapper's Borg slot and the Borg compute core.
- CPU writes are buffered into a command FIFO and presented to the core on a valid/ready stream.
- Core results return through a result FIFO, which the CPU reads with bus stalling when it is empty.
- Decouples CPU bus timing from core compute latency; drives the Borg result interrupt.

Parameters:
CMD_DEPTH, 4, command FIFO entries; power of two, at least 2.
RES_DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-high reset
io_address  in  6  register offset within the peripheral slot
io_data_in  in  32  CPU write data
io_data_write_n  in  2  11 = idle, 00 = byte, 01 = half, 10 = word
io_data_read_n  in  2  same encoding as io_data_write_n, for reads
io_data_out  out  32  read data, combinational from the addressed register
io_data_ready  out  1  read data valid / read may complete
io_user_interrupt  out  1  result-available interrupt
io_cmd_valid  out  1  command FIFO not empty
io_cmd_ready  in  1  core accepts command
io_cmd_bits  out  32  command FIFO head
io_res_valid  in  1  core offers result
io_res_ready  out  1  result FIFO not full
io_res_bits  in  32  result word

Behaviour:
Reset (synchronous, active-high):
- Both FIFOs empty; overflow = 0; ie = 0; served = 0.
- All outputs 0, except io_data_ready = 1 and io_res_ready = 1.

Register map (io_address):
- 0x00 CMD, write-only. A write pushes the zero-extended write data: byte → data_in[7:0], half → data_in[15:0], word → all 32 bits. Reads of CMD return 0.
- 0x04 RESULT, read-only. A read pops the result FIFO head; io_data_out = head.
- 0x08 STATUS, read: bit0 res_empty, bit1 cmd_full, bit2 overflow, bits[11:8] cmd_count, bits[19:16] res_count, all other bits 0. A write with data_in[2] = 1 clears overflow.
- 0x0C CTRL, read/write: bit1 = ie. Writing bit0 = 1 flushes both FIFOs and clears overflow in that cycle. bit0 always reads 0.
- Any other offset: reads return 0 with ready = 1; writes are ignored.

Command FIFO:
- io_cmd_valid = !cmd_empty; io_cmd_bits = head. Pop on io_cmd_valid && io_cmd_ready.
- A CMD write when full is dropped and sets sticky overflow. Exception: if a pop occurs in the same cycle, the write is accepted and overflow is not set.
- io_cmd_bits must stay stable while valid && !ready.

Result FIFO:
- io_res_ready = !res_full. Push on io_res_valid && io_res_ready.

Read handshake:
- served flag: set when a read is active (read_n != 11) and io_data_ready = 1; cleared when read_n returns to 11.
- RESULT read, served = 0, FIFO empty → io_data_ready = 0 (stall); no pop.
- RESULT read, served = 0, FIFO non-empty → io_data_ready = 1 and exactly one pop that cycle.
- Further cycles of the same read transaction (served = 1): io_data_ready = 1, no further pops.
- All other reads, and idle cycles: io_data_ready = 1.

Boundary cases:
- Simultaneous push and pop on the result FIFO: both occur and the count is unchanged.
- Push into an empty result FIFO during a stalled read: the push lands; the next cycle gives ready = 1 with that word and pops it.
- Flush is dominant: same-cycle core push/pop and CPU CMD write are discarded. Counts become 0 the next cycle.
- Reset mid-stall: served cleared and FIFOs emptied; the read keeps stalling until a result is pushed.

Pointers and interrupt:
- Pointers wrap modulo depth; counts are log2(depth)+1 bits, zero-extended into the STATUS fields.
- io_user_interrupt = ie && !res_empty, registered: updates one cycle after the state change.

Test Plan:
1. Word writes 0x11, 0x22, 0x33 to CMD with cmd_ready = 0 → cmd_count = 3, io_cmd_bits = 0x11. Then cmd_ready = 1 → bits stream out 0x11, 0x22, 0x33 on consecutive cycles, then io_cmd_valid = 0.
2. Five CMD writes with cmd_ready = 0 and CMD_DEPTH = 4 → fifth dropped, STATUS bit2 = 1, cmd_full = 1. Write STATUS with data_in = 0x4 → overflow = 0.
3. RESULT read held with the FIFO empty for 5 cycles → io_data_ready = 0 throughout. Core pushes 0xDEADBEEF → next cycle ready = 1, data_out = 0xDEADBEEF, res_count returns to 0.
4. Push results 0xA, 0xB; hold a single RESULT read for 3 cycles → only 0xA popped, res_count = 1. A second read returns 0xB.
5. Write CTRL = 0x2, then core pushes a result → io_user_interrupt = 1 one cycle later. A RESULT read that empties the FIFO → interrupt drops to 0.
6. cmd_count = 2, res_count = 3, overflow = 1; write CTRL = 0x1 while the core pushes → STATUS reads 0x1 (all counts 0, overflow 0); the pushed result is discarded.
